// File: rtl/calc_operand_loader.sv
// calc_operand_loader
// Streams two operand vectors (A1 then A2) of N_LANES signed 16-bit lanes
// from a valid/ready element stream. It then issues a one-cycle sum or
// multiply command to the calculator, waits WAIT_CYCLES cycles and pulses
// done.
//
// Ports
//   clk       : single clock, all state updates on posedge
//   rst       : asynchronous active-high reset
//   start     : request a new load, sampled only in IDLE
//   op_sel    : 0 = sum, 1 = multiply, latched together with start
//   clear     : synchronous abort to IDLE; highest priority after rst
//   in_valid  : in_data carries a valid element
//   in_data   : opaque signed 16-bit element
//   in_ready  : element accepted this cycle (LOAD_A / LOAD_B only)
//   A1, A2    : operand vectors, lane i at [16*i +: 16]
//   sum       : one-cycle sum command (ISSUE state)
//   multiply  : one-cycle multiply command (ISSUE state)
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse, calculator results valid
module calc_operand_loader #(
  parameter int unsigned N_LANES     = 32,  // 1..32
  parameter int unsigned WAIT_CYCLES = 1    // 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sel,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [15:0]           in_data,
  output logic                  in_ready,
  output logic [N_LANES*16-1:0] A1,
  output logic [N_LANES*16-1:0] A2,
  output logic                  sum,
  output logic                  multiply,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LANE_W = 16;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned WCNT_W = 4;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_LANES - 1);
  localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_op;

  logic                w_last;

  // Ready is a pure decode of the state register.
  assign in_ready = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_last   = (r_idx == LAST_IDX);

  // Control FSM, lane writes and registered command/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_op     <= 1'b0;
      A1       <= '0;
      A2       <= '0;
      sum      <= 1'b0;
      multiply <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      // Abort: vectors keep their contents, a coincident transfer is dropped.
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_wcnt   <= '0;
      sum      <= 1'b0;
      multiply <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sum      <= 1'b0;
      multiply <= 1'b0;
      done     <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op_sel;
            r_idx   <= '0;
            r_state <= ST_LOAD_A;
            busy    <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
              if (r_idx == IDX_W'(i)) A1[i*LANE_W +: LANE_W] <= in_data;
            end
            if (w_last) begin
              r_idx   <= '0;
              r_state <= ST_LOAD_B;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
              if (r_idx == IDX_W'(i)) A2[i*LANE_W +: LANE_W] <= in_data;
            end
            if (w_last) begin
              // Command is registered so it is high exactly during ISSUE.
              r_idx    <= '0;
              r_state  <= ST_ISSUE;
              sum      <= ~r_op;
              multiply <= r_op;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_wcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wcnt == LAST_WAIT) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_loader.sv
// Self-checking bench for calc_operand_loader: two instances (WAIT_CYCLES 1
// and 4) share all inputs; a lane-array model tracks expected vector contents.
`timescale 1ns/1ps
module tb_calc_operand_loader;

  localparam int NL = 32;
  localparam int VW = NL * 16;

  logic          clk = 1'b0;
  logic          rst, start, op_sel, clear, in_valid;
  logic [15:0]   in_data;
  logic          in_ready, sum, multiply, busy, done;
  logic [VW-1:0] A1, A2;
  logic          in_ready4, sum4, mul4, busy4, done4;
  logic [VW-1:0] A1_4, A2_4;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_sum = 0, n_mul = 0, n_done = 0, t_sum = 0, t_done = 0;
  int n_both = 0, rdy_err = 0;
  int n_done4 = 0, t_cmd4 = 0, t_done4 = 0;
  int ld_err = 0, last_cyc = 0;

  logic [15:0] sa [NL];
  logic [15:0] sb [NL];
  logic [15:0] ea [NL];
  logic [15:0] eb [NL];

  calc_operand_loader #(.N_LANES(NL), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .A1(A1), .A2(A2), .sum(sum), .multiply(multiply), .busy(busy), .done(done)
  );

  calc_operand_loader #(.N_LANES(NL), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .A1(A1_4), .A2(A2_4), .sum(sum4), .multiply(mul4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor; ready must never be seen outside a load phase.
  always @(negedge clk) begin
    if (sum)      begin n_sum  <= n_sum + 1;  t_sum  <= cyc; end
    if (multiply) begin n_mul  <= n_mul + 1;  t_sum  <= cyc; end
    if (done)     begin n_done <= n_done + 1; t_done <= cyc; end
    if (sum && multiply) n_both <= n_both + 1;
    if ((in_ready && (!busy || sum || multiply || done)) ||
        (in_ready4 && (!busy4 || sum4 || mul4 || done4)))
      rdy_err <= rdy_err + 1;
    if (sum4 || mul4) t_cmd4 <= cyc;
    if (done4) begin n_done4 <= n_done4 + 1; t_done4 <= cyc; end
  end

  function automatic logic [15:0] lane(input logic [VW-1:0] v, input int i);
    return v[i*16 +: 16];
  endfunction

  function automatic int lanes_bad();
    int b = 0;
    for (int i = 0; i < NL; i++) begin
      if (lane(A1, i) !== ea[i]) b++;
      if (lane(A2, i) !== eb[i]) b++;
    end
    return b;
  endfunction

  task automatic prep();
    @(negedge clk);
    clear = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic begin_op(input logic op);
    @(negedge clk);
    start = 1'b1; op_sel = op;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Deliver count elements (A1 then A2) with random gaps; model updated on accept.
  task automatic stream(input int count, input int gap_pct);
    int n = 0;
    int budget = 0;
    while (n < count && budget < 4000) begin
      @(negedge clk);
      budget++;
      in_valid = 1'b0;
      if (!in_ready) ld_err++;
      else if (int'($urandom_range(99)) >= gap_pct) begin
        in_valid = 1'b1;
        if (n < NL) begin in_data = sa[n]; ea[n] = sa[n]; end
        else begin in_data = sb[n-NL]; eb[n-NL] = sb[n-NL]; end
        n++;
      end
    end
    if (n < count) ld_err++;
    last_cyc = cyc;
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (n_done <= base && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_sel = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NL; i++) begin ea[i] = '0; eb[i] = '0; end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({sum, multiply, done} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {sum, multiply, done}); end
    checks++; if (A1 !== '0 || A2 !== '0) begin failures++; $display("FAIL reset_vectors got=%0d nonzero lanes exp=0", lanes_bad()); end
    checks++; if ({busy4, in_ready4, done4} !== 3'b000) begin failures++; $display("FAIL reset_dut4 got=%b exp=000", {busy4, in_ready4, done4}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sum();
    int bs, bm, bd;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'(i); sb[i] = 16'd100; end
    bs = n_sum; bm = n_mul; bd = n_done;
    begin_op(1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sum_busy got=%b exp=1", busy); end
    stream(2*NL, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(bd);
    repeat (3) @(negedge clk);
    checks++; if (n_sum - bs !== 1) begin failures++; $display("FAIL sum_pulse_count got=%0d exp=1", n_sum - bs); end
    checks++; if (n_mul - bm !== 0) begin failures++; $display("FAIL sum_no_mul got=%0d exp=0", n_mul - bm); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL sum_done_count got=%0d exp=1", n_done - bd); end
    checks++; if (t_sum !== last_cyc + 1) begin failures++; $display("FAIL sum_issue_time got=%0d exp=%0d", t_sum, last_cyc + 1); end
    checks++; if (t_done - t_sum !== 2) begin failures++; $display("FAIL sum_done_latency got=%0d exp=2", t_done - t_sum); end
    checks++; if (lane(A1, 31) !== 16'd31) begin failures++; $display("FAIL sum_a1_31 got=%0h exp=1f", lane(A1, 31)); end
    checks++; if (lane(A2, 0) !== 16'd100) begin failures++; $display("FAIL sum_a2_0 got=%0h exp=64", lane(A2, 0)); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL sum_lanes got=%0d bad exp=0", lanes_bad()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sum_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul_gaps();
    int bs, bm, bd, le;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'(-i); sb[i] = 16'd3; end
    bs = n_sum; bm = n_mul; bd = n_done; le = ld_err;
    begin_op(1'b1);
    op_sel = 1'b0;  // must not affect the latched operation
    stream(2*NL, 50);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(bd);
    repeat (3) @(negedge clk);
    checks++; if (n_mul - bm !== 1) begin failures++; $display("FAIL mul_pulse_count got=%0d exp=1", n_mul - bm); end
    checks++; if (n_sum - bs !== 0) begin failures++; $display("FAIL mul_no_sum got=%0d exp=0", n_sum - bs); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL mul_done_count got=%0d exp=1", n_done - bd); end
    checks++; if (lane(A1, 5) !== 16'hFFFB) begin failures++; $display("FAIL mul_a1_5 got=%0h exp=fffb", lane(A1, 5)); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL mul_lanes got=%0d bad exp=0", lanes_bad()); end
    checks++; if (ld_err - le !== 0) begin failures++; $display("FAIL mul_ready_during_load got=%0d stalls exp=0", ld_err - le); end
  endtask

  task automatic test_start_busy();
    int bs, bm, bd;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    bs = n_sum; bm = n_mul; bd = n_done;
    begin_op(1'b0);
    start = 1'b1; op_sel = 1'b1;
    stream(2*NL, 20);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    wait_done(bd);
    repeat (6) @(negedge clk);
    checks++; if (n_sum - bs !== 1) begin failures++; $display("FAIL busy_start_sum got=%0d exp=1", n_sum - bs); end
    checks++; if (n_mul - bm !== 0) begin failures++; $display("FAIL busy_start_mul got=%0d exp=0", n_mul - bm); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL busy_start_done got=%0d exp=1", n_done - bd); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL busy_start_lanes got=%0d bad exp=0", lanes_bad()); end
  endtask

  task automatic test_clear();
    int bs, bm, bd;
    logic [15:0] old;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    bs = n_sum; bm = n_mul; bd = n_done;
    begin_op(1'b0);
    stream(NL + 10, 0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clear_pre_ready got=%b exp=1", in_ready); end
    old = eb[10];
    in_valid = 1'b1; in_data = ~old; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%b exp=0", in_ready); end
    checks++; if (lane(A2, 10) !== old) begin failures++; $display("FAIL clear_a2_10 got=%0h exp=%0h", lane(A2, 10), old); end
    repeat (10) @(negedge clk);
    checks++; if ((n_sum - bs) + (n_mul - bm) + (n_done - bd) !== 0) begin
      failures++; $display("FAIL clear_no_pulses got=%0d exp=0", (n_sum - bs) + (n_mul - bm) + (n_done - bd)); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL clear_lanes got=%0d bad exp=0", lanes_bad()); end
  endtask

  task automatic test_rst_wait();
    int bm, bd;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    begin_op(1'b0);
    stream(2*NL, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    bd = n_done;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    checks++; if ({in_ready, sum, multiply, done} !== 4'b0000) begin failures++; $display("FAIL rst_async_outs got=%b exp=0000", {in_ready, sum, multiply, done}); end
    checks++; if (A1 !== '0 || A2 !== '0) begin failures++; $display("FAIL rst_async_vectors got=nonzero exp=0"); end
    #1 rst = 1'b0;
    for (int i = 0; i < NL; i++) begin ea[i] = '0; eb[i] = '0; end
    repeat (6) @(negedge clk);
    checks++; if (n_done - bd !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", n_done - bd); end
    for (int i = 0; i < NL; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    bm = n_mul; bd = n_done;
    begin_op(1'b1);
    stream(2*NL, 50);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(bd);
    repeat (3) @(negedge clk);
    checks++; if (n_mul - bm !== 1) begin failures++; $display("FAIL rst_after_mul got=%0d exp=1", n_mul - bm); end
    checks++; if (n_done - bd !== 1) begin failures++; $display("FAIL rst_after_done got=%0d exp=1", n_done - bd); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL rst_after_lanes got=%0d bad exp=0", lanes_bad()); end
  endtask

  task automatic test_wait4();
    int bd4;
    int k = 0;
    prep();
    for (int i = 0; i < NL; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    bd4 = n_done4;
    begin_op(1'b0);
    stream(2*NL, 30);
    @(negedge clk);
    in_valid = 1'b0;
    while (n_done4 <= bd4 && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++; if (n_done4 - bd4 !== 1) begin failures++; $display("FAIL wait4_done_count got=%0d exp=1", n_done4 - bd4); end
    checks++; if (t_done4 - t_cmd4 !== 5) begin failures++; $display("FAIL wait4_latency got=%0d exp=5", t_done4 - t_cmd4); end
    checks++; if (t_done - t_sum !== 2) begin failures++; $display("FAIL wait1_latency got=%0d exp=2", t_done - t_sum); end
    checks++; if (A1_4 !== A1 || A2_4 !== A2) begin failures++; $display("FAIL wait4_vectors got=differ exp=equal"); end
    checks++; if (lanes_bad() !== 0) begin failures++; $display("FAIL wait4_lanes got=%0d bad exp=0", lanes_bad()); end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_mul_gaps();
    test_start_busy();
    test_clear();
    test_rst_wait();
    test_wait4();
    repeat (2) @(negedge clk);
    checks++; if (n_both !== 0) begin failures++; $display("FAIL cmd_both got=%0d exp=0", n_both); end
    checks++; if (rdy_err !== 0) begin failures++; $display("FAIL ready_outside_load got=%0d exp=0", rdy_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
